// File: rtl/bios_shadow_copier.sv
// rtl/bios_shadow_copier.sv - copies the BIOS ROM image to main memory in bursts before releasing CPU reset
module bios_shadow_copier #(
    parameter int          ROM_WORDS = 2048,
    parameter int          BURST_LEN = 8,
    parameter logic [31:0] DEST_BASE = 32'h0000_0000,
    parameter logic [31:0] MAGIC     = 32'hEFBE_ADDE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [10:0] romAddress,
    input  logic [31:0] romData,
    output logic        busRequest,
    input  logic        busGrant,
    output logic        wrValid,
    input  logic        wrReady,
    output logic [31:0] wrAddress,
    output logic [31:0] wrData,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpuReset
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_REQ     = 3'd2,
        S_BURST   = 3'd3,
        S_RELEASE = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    // Beat counter is wide enough for BURST_LEN up to 64.
    localparam logic [6:0]  LAST_BEAT = 7'(BURST_LEN - 1);
    localparam logic [10:0] LAST_WORD = 11'(ROM_WORDS - 1);

    state_t      state_q, state_d;
    logic [10:0] addr_q, addr_d;
    logic [6:0]  beat_q, beat_d;

    // State and counter registers; reset aborts any copy in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 11'd0;
            beat_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state and counter update; a beat only counts while the grant is held.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_CHECK;
                    addr_d  = 11'd0;
                end
            end
            S_CHECK: begin
                state_d = (romData == MAGIC) ? S_REQ : S_ERROR;
            end
            S_REQ: begin
                if (busGrant) begin
                    state_d = S_BURST;
                    beat_d  = 7'd0;
                end
            end
            S_BURST: begin
                if (!busGrant) begin
                    state_d = S_ERROR;
                end else if (wrReady) begin
                    addr_d = addr_q + 11'd1;
                    beat_d = beat_q + 7'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = (addr_q == LAST_WORD) ? S_DONE : S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                state_d = S_REQ;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state so reset drops them asynchronously.
    always_comb begin
        busRequest = 1'b0;
        wrValid    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        cpuReset   = 1'b1;
        case (state_q)
            S_IDLE:  busy = 1'b0;
            S_REQ:   busRequest = 1'b1;
            S_BURST: begin
                busRequest = 1'b1;
                wrValid    = 1'b1;
            end
            S_DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                cpuReset = 1'b0;
            end
            S_ERROR: begin
                busy  = 1'b0;
                error = 1'b1;
            end
            default: ;
        endcase
    end

    assign romAddress = addr_q;
    assign wrAddress  = DEST_BASE + {19'd0, addr_q, 2'b00};
    assign wrData     = romData;

endmodule

// File: tb/tb_bios_shadow_copier.sv
// tb/tb_bios_shadow_copier.sv - randomized self-checking bench for bios_shadow_copier
module tb_bios_shadow_copier;

    localparam int          NW    = 16;
    localparam int          BL    = 8;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] MAGIC = 32'hEFBE_ADDE;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] romAddress;
    logic [31:0] romData;
    logic        busRequest;
    logic        busGrant = 1'b0;
    logic        wrValid;
    logic        wrReady = 1'b0;
    logic [31:0] wrAddress;
    logic [31:0] wrData;
    logic        busy, done, error, cpuReset;

    logic [31:0] rom [NW];
    int checks = 0;
    int errors = 0;

    int  arb_mode   = 0;   // 0 automatic arbiter, 1 driven by the main sequence
    int  max_delay  = 0;
    int  ready_mode = 0;   // 0 always, 1 pattern 1,0,0, 2 random
    int  rdy_ph     = 0;
    int  gwait      = 0;
    int  model_idx  = 0;   // next ROM word the reference expects on the bus
    bit  rel_pending = 0;
    bit  no_bus      = 0;
    bit  stalled     = 0;
    logic [10:0] prev_ra;
    logic [31:0] prev_wa, prev_wd;
    int  cyc;

    bios_shadow_copier #(
        .ROM_WORDS(NW), .BURST_LEN(BL), .DEST_BASE(BASE), .MAGIC(MAGIC)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .romAddress(romAddress),
        .romData(romData), .busRequest(busRequest), .busGrant(busGrant),
        .wrValid(wrValid), .wrReady(wrReady), .wrAddress(wrAddress),
        .wrData(wrData), .busy(busy), .done(done), .error(error), .cpuReset(cpuReset)
    );

    always #5 clock = ~clock;

    assign romData = (romAddress < 11'(NW)) ? rom[romAddress[3:0]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fill_rom(input bit good);
        for (int i = 0; i < NW; i++) rom[i] = $urandom;
        rom[0] = good ? MAGIC : 32'h0000_0000;
    endtask

    // Issue a start pulse and wait for DONE or ERROR; optional stray starts while busy.
    task automatic run_copy(input bit extra_starts, input bit check_timing, output int cycles);
        model_idx = 0;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
        chk("start_err_clr", error, 0);
        chk("start_cpurst", cpuReset, 1);
        cycles = 0;
        while (!done && !error && cycles < 2000) begin
            start = extra_starts && busy && ($urandom_range(0, 3) == 0);
            @(posedge clock); #1;
            start = 1'b0;
            cycles++;
            if (check_timing && cycles == 1) chk("first_req_t2", busRequest, 1);
        end
        chk("copy_timeout", (cycles < 2000), 1);
    endtask

    // Arbiter and write-ready responder.
    initial begin
        forever begin
            @(posedge clock); #1;
            case (ready_mode)
                0: wrReady = 1'b1;
                1: begin
                    wrReady = (rdy_ph == 0);
                    rdy_ph  = (rdy_ph + 1) % 3;
                end
                default: wrReady = 1'($urandom_range(0, 1));
            endcase
            if (arb_mode == 0) begin
                if (!busRequest) begin
                    busGrant = 1'b0;
                    gwait    = $urandom_range(0, max_delay);
                end else if (!busGrant) begin
                    if (gwait == 0) busGrant = 1'b1;
                    else gwait--;
                end
            end
        end
    end

    // Bus monitor: every accepted beat must be the next ROM word at its destination address.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                stalled     = 0;
                rel_pending = 0;
            end else begin
                if (no_bus) begin
                    chk("nobus_req", busRequest, 0);
                    chk("nobus_wvalid", wrValid, 0);
                end
                if (rel_pending) begin
                    chk("release_req_low", busRequest, 0);
                    rel_pending = 0;
                end
                if (stalled && wrValid) begin
                    chk("stall_romaddr", 32'(romAddress), 32'(prev_ra));
                    chk("stall_wraddr", wrAddress, prev_wa);
                    chk("stall_wrdata", wrData, prev_wd);
                end
                if (wrValid && wrReady && busGrant) begin
                    chk("beat_in_range", (model_idx < NW), 1);
                    if (model_idx < NW) begin
                        chk("beat_addr", wrAddress, BASE + 32'(4 * model_idx));
                        chk("beat_data", wrData, rom[model_idx]);
                    end
                    model_idx++;
                    if (model_idx % BL == 0 && model_idx < NW) rel_pending = 1;
                end
                stalled = wrValid && !wrReady && busGrant;
                prev_ra = romAddress;
                prev_wa = wrAddress;
                prev_wd = wrData;
            end
        end
    end

    initial begin
        fill_rom(1);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        // Reset state
        chk("rst_romaddr", 32'(romAddress), 0);
        chk("rst_req", busRequest, 0);
        chk("rst_wvalid", wrValid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_cpurst", cpuReset, 1);

        // Normal copy at full rate: exact cycle count and final flags
        run_copy(0, 1, cyc);
        chk("normal_cycles", cyc, 1 + (NW / BL) * (BL + 2) - 1);
        chk("normal_beats", model_idx, NW);
        chk("normal_done", done, 1);
        chk("normal_cpurst", cpuReset, 0);
        chk("normal_busy", busy, 0);

        // Bad magic: ERROR right after CHECK, bus never touched
        fill_rom(0);
        no_bus = 1;
        run_copy(0, 0, cyc);
        chk("bad_cycles", cyc, 1);
        chk("bad_error", error, 1);
        chk("bad_cpurst", cpuReset, 1);
        repeat (3) @(posedge clock);
        no_bus = 0;

        // Backpressure pattern 1,0,0
        fill_rom(1);
        ready_mode = 1;
        run_copy(0, 0, cyc);
        chk("bp_beats", model_idx, NW);
        chk("bp_done", done, 1);

        // Grant withheld 20 cycles, then dropped after the 3rd beat
        ready_mode = 0;
        arb_mode   = 1;
        busGrant   = 1'b0;
        model_idx  = 0;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < 20; i++) begin
            chk("wait_req", busRequest, 1);
            chk("wait_wvalid", wrValid, 0);
            @(posedge clock); #1;
        end
        busGrant = 1'b1;
        chk("grant_cycle_wvalid", wrValid, 0);
        @(posedge clock); #1;
        chk("grant_plus1_wvalid", wrValid, 1);
        repeat (3) @(posedge clock);
        #1 busGrant = 1'b0;
        @(posedge clock); #1;
        chk("drop_error", error, 1);
        chk("drop_cpurst", cpuReset, 1);
        chk("drop_busy", busy, 0);
        chk("drop_req", busRequest, 0);
        chk("drop_beats", model_idx, 3);
        arb_mode = 0;
        run_copy(0, 0, cyc);
        chk("drop_recopy_beats", model_idx, NW);
        chk("drop_recopy_done", done, 1);

        // Reset mid-burst at romAddress 5
        model_idx = 0;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        cyc = 0;
        while (!(wrValid && romAddress == 11'd5) && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk("reach_addr5", (cyc < 200), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_req", busRequest, 0);
        chk("arst_wvalid", wrValid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cpurst", cpuReset, 1);
        chk("arst_romaddr", 32'(romAddress), 0);
        @(negedge clock);
        @(posedge clock); #1 reset = 1'b0;
        chk("arst_beats", model_idx, 5);
        run_copy(0, 0, cyc);
        chk("arst_recopy_beats", model_idx, NW);

        // Randomized runs with stray starts while busy, each restarted from DONE
        ready_mode = 2;
        for (int r = 0; r < 4; r++) begin
            fill_rom(1);
            max_delay = $urandom_range(0, 6);
            run_copy(1, 0, cyc);
            chk("rand_beats", model_idx, NW);
            chk("rand_done", done, 1);
            chk("rand_cpurst", cpuReset, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

endmodule
